// File: rtl/alu_pipe_pkg.sv
// Shared opcode encoding, opcode width and flag payload for the pipelined ALU.
package alu_pipe_pkg;

  localparam int unsigned F_W = 3;

  localparam logic [F_W-1:0] OP_AND  = 3'b000;
  localparam logic [F_W-1:0] OP_OR   = 3'b001;
  localparam logic [F_W-1:0] OP_ADD  = 3'b010;
  localparam logic [F_W-1:0] OP_RSVD = 3'b011;
  localparam logic [F_W-1:0] OP_ANDN = 3'b100;
  localparam logic [F_W-1:0] OP_ORN  = 3'b101;
  localparam logic [F_W-1:0] OP_SUB  = 3'b110;
  localparam logic [F_W-1:0] OP_SLT  = 3'b111;

  typedef struct packed {
    logic carry;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath: F[2] inverts B and injects carry-in, F selects the operation.
module alu_core
  import alu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [F_W-1:0]   f,
  output logic [WIDTH-1:0] result_c,
  output logic             carry_c,
  output logic             overflow_c
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             sum_ovf;

  always_comb begin
    b_eff   = f[2] ? ~b : b;
    sum     = {1'b0, a} + {1'b0, b_eff} + (WIDTH+1)'(f[2]);
    sum_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

  // Flags are only meaningful for ADD/SUB; every other opcode reports them as zero.
  always_comb begin
    result_c   = '0;
    carry_c    = 1'b0;
    overflow_c = 1'b0;
    case (f)
      OP_AND, OP_ANDN: result_c = a & b_eff;
      OP_OR,  OP_ORN:  result_c = a | b_eff;
      OP_ADD, OP_SUB: begin
        result_c   = sum[WIDTH-1:0];
        carry_c    = sum[WIDTH];
        overflow_c = sum_ovf;
      end
      OP_SLT:  result_c = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ sum_ovf};
      OP_RSVD: result_c = '0;
      default: result_c = '0;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: stage 1 holds operands, stage 2 holds result and flags.
// Optional ALU_PIPE_ZN_EN adds registered Zero/Negative outputs.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [F_W-1:0]   F,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             Overflow
`ifdef ALU_PIPE_ZN_EN
  ,
  output logic             Zero,
  output logic             Negative
`endif
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [F_W-1:0]   f_q, f_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  alu_flags_t       flags_q, flags_d;

  logic [WIDTH-1:0] core_result_c;
  logic             core_carry_c;
  logic             core_overflow_c;
  logic             adv2;
  logic             accept;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a          (a_q),
    .b          (b_q),
    .f          (f_q),
    .result_c   (core_result_c),
    .carry_c    (core_carry_c),
    .overflow_c (core_overflow_c)
  );

  // Stage 1 drains into stage 2 whenever stage 2 is empty or being emptied this cycle.
  assign adv2     = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || adv2;
  assign accept   = in_valid && in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    f_d        = f_q;
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    flags_d    = flags_q;

    if (adv2)   s1_valid_d = 1'b0;
    if (accept) begin
      s1_valid_d = 1'b1;
      a_d        = A;
      b_d        = B;
      f_d        = F;
    end

    if (s2_valid_q && out_ready) s2_valid_d = 1'b0;
    if (adv2) begin
      s2_valid_d       = 1'b1;
      result_d         = core_result_c;
      flags_d.carry    = core_carry_c;
      flags_d.overflow = core_overflow_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      f_q        <= '0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      f_q        <= f_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign Result    = result_q;
  assign CarryOut  = flags_q.carry;
  assign Overflow  = flags_q.overflow;

`ifdef ALU_PIPE_ZN_EN
  logic zero_q, zero_d;
  logic neg_q, neg_d;

  // Zero/Negative are captured alongside Result so they stall with it.
  always_comb begin
    zero_d = zero_q;
    neg_d  = neg_q;
    if (adv2) begin
      zero_d = (core_result_c == '0);
      neg_d  = core_result_c[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      neg_q  <= neg_d;
    end
  end

  assign Zero     = zero_q;
  assign Negative = neg_q;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=4): directed vectors, backpressure and mid-flight reset.
module tb_alu_pipe;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   F;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Result;
  logic         CarryOut;
  logic         Overflow;
`ifdef ALU_PIPE_ZN_EN
  logic         Zero;
  logic         Negative;
`endif

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .F         (F),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .CarryOut  (CarryOut),
    .Overflow  (Overflow)
`ifdef ALU_PIPE_ZN_EN
    ,
    .Zero      (Zero),
    .Negative  (Negative)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         z;
    logic         n;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one transaction, waits (bounded) for acceptance, records the expected result.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f,
                      input logic [W-1:0] r, input logic c, input logic v);
    bit ok;
    ok = 1'b0;
    A = a; B = b; F = f; in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{r, c, v, (r == 4'd0), r[W-1]});
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: in_ready stayed 0 for op %b", f);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: %0d results still outstanding, expected 0", name, sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    chk({name, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_result"},    32'(Result),    32'd0);
    chk({name, "_carry"},     32'(CarryOut),  32'd0);
    chk({name, "_overflow"},  32'(Overflow),  32'd0);
    chk({name, "_in_ready"},  32'(in_ready),  32'd1);
  endtask

  // Monitor: every output transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got %b with no outstanding item", Result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_flags", 32'({Result, CarryOut, Overflow}), 32'({e.r, e.c, e.v}));
`ifdef ALU_PIPE_ZN_EN
        chk("zero_neg", 32'({Zero, Negative}), 32'({e.z, e.n}));
`endif
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; F = '0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed single operations
    send(4'b0011, 4'b1010, 3'b110, 4'b1001, 1'b0, 1'b1);
    send(4'b0101, 4'b0001, 3'b101, 4'b1111, 1'b0, 1'b0);
    send(4'b1010, 4'b1101, 3'b010, 4'b0111, 1'b1, 1'b1);
    send(4'b1001, 4'b0111, 3'b111, 4'b0001, 1'b0, 1'b0);
    send(4'b0101, 4'b1001, 3'b111, 4'b0000, 1'b0, 1'b0);
    send(4'b1111, 4'b1111, 3'b011, 4'b0000, 1'b0, 1'b0);
    send(4'b1100, 4'b1010, 3'b100, 4'b0100, 1'b0, 1'b0);
    send(4'b0111, 4'b0001, 3'b010, 4'b1000, 1'b0, 1'b1);
    drain("drain_directed");

    // Back-to-back under backpressure: two accepts then stall, output held
    out_ready = 1'b0;
    fork
      begin
        send(4'b0001, 4'b0010, 3'b010, 4'b0011, 1'b0, 1'b0);
        send(4'b1100, 4'b1010, 3'b000, 4'b1000, 1'b0, 1'b0);
        send(4'b0101, 4'b0010, 3'b001, 4'b0111, 1'b0, 1'b0);
        send(4'b0111, 4'b0010, 3'b110, 4'b0101, 1'b1, 1'b0);
      end
      begin
        repeat (3) @(negedge clk);
        chk("stall_in_ready",  32'(in_ready),  32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_result",    32'(Result),    32'h3);
        @(negedge clk);
        chk("hold_out_valid",  32'(out_valid), 32'd1);
        chk("hold_result",     32'(Result),    32'h3);
        chk("hold_in_ready",   32'(in_ready),  32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");

    // Reset with both stages full discards in-flight items
    out_ready = 1'b0;
    send(4'b0001, 4'b0001, 3'b010, 4'b0010, 1'b0, 1'b0);
    send(4'b0011, 4'b0001, 3'b010, 4'b0100, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_idle("midreset");
    @(posedge clk);
    #1;
    send(4'b0110, 4'b0011, 3'b110, 4'b0011, 1'b1, 1'b0);
    drain("drain_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
